// File: rtl/sdr_req_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM request port between N_REQ requesters.
// Optional watchdog (forced completion + sticky timeout_err) is enabled by defining SDR_ARB_TIMEOUT_EN.
module sdr_req_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      ioctl_downl,
    input  logic [N_REQ-1:0]          req_tog,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*2-1:0]        req_be,
    input  logic [N_REQ-1:0]          req_we,
    output logic [N_REQ-1:0]          ack_tog,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          rvalid,
    output logic [ADDR_W-1:0]         sdr_addr,
    output logic [DATA_W-1:0]         sdr_data,
    output logic [1:0]                sdr_be,
    output logic                      sdr_we,
    output logic                      sdr_req,
    input  logic                      sdr_ack,
    input  logic [DATA_W-1:0]         sdr_q,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic [N_REQ-1:0]   pend;
    logic [N_REQ-1:0]   elig;
    logic               acked;
    logic               timed_out;

    logic [ADDR_W-1:0]  addr_slice [N_REQ];
    logic [DATA_W-1:0]  data_slice [N_REQ];
    logic [1:0]         be_slice   [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_slice[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_slice[i] = req_data[i*DATA_W +: DATA_W];
            be_slice[i]   = req_be[i*2 +: 2];
        end
    end

    // During download only the loader (bit 0) may be granted.
    assign pend = req_tog ^ ack_tog;
    assign elig = pend & {{(N_REQ-1){~ioctl_downl}}, 1'b1};

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand  = '0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign acked = (state == WAIT) && (sdr_ack == sdr_req);
    assign busy  = (state == ISSUE) || (state == WAIT);

`ifdef SDR_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign timed_out = (state == WAIT) && !acked && (wait_cnt == 16'hFFFF);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 16'd1;
            if (timed_out)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (acked || timed_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            grant      <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            ack_tog    <= '0;
            rdata      <= '0;
            rvalid     <= '0;
            sdr_addr   <= '0;
            sdr_data   <= '0;
            sdr_be     <= '0;
            sdr_we     <= 1'b0;
            sdr_req    <= 1'b0;
        end else begin
            // NOTE: default-low here makes rvalid a single-cycle pulse without extra state.
            rvalid <= '0;
            case (state)
                IDLE: begin
                    if (found)
                        grant <= pick;
                end
                ISSUE: begin
                    sdr_addr   <= addr_slice[grant];
                    sdr_data   <= data_slice[grant];
                    sdr_be     <= be_slice[grant];
                    sdr_we     <= req_we[grant];
                    sdr_req    <= ~sdr_req;
                    last_grant <= grant;
                end
                WAIT: begin
                    if (acked) begin
                        ack_tog[grant] <= ~ack_tog[grant];
                        if (!sdr_we) begin
                            rdata         <= sdr_q;
                            rvalid[grant] <= 1'b1;
                        end
                    end else if (timed_out) begin
                        // Realign the controller handshake so the next ISSUE starts cleanly.
                        ack_tog[grant] <= ~ack_tog[grant];
                        sdr_req        <= sdr_ack;
                        rdata          <= DATA_W'(16'hDEAD);
                        if (!sdr_we)
                            rvalid[grant] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_req_arbiter.sv
// Randomized self-checking bench for sdr_req_arbiter against a transaction-level reference model.
// The watchdog scenario is exercised only when SDR_ARB_TIMEOUT_EN is defined.
module tb_sdr_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 16;

    logic              sys_clk = 1'b0;
    logic              reset_n;
    logic              ioctl_downl;
    logic [N-1:0]      req_tog;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*2-1:0]    req_be;
    logic [N-1:0]      req_we;
    logic [N-1:0]      ack_tog;
    logic [DW-1:0]     rdata;
    logic [N-1:0]      rvalid;
    logic [AW-1:0]     sdr_addr;
    logic [DW-1:0]     sdr_data;
    logic [1:0]        sdr_be;
    logic              sdr_we;
    logic              sdr_req;
    logic              sdr_ack;
    logic [DW-1:0]     sdr_q;
    logic              busy;
    logic              timeout_err;

    sdr_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .req_tog     (req_tog),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_be      (req_be),
        .req_we      (req_we),
        .ack_tog     (ack_tog),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .sdr_addr    (sdr_addr),
        .sdr_data    (sdr_data),
        .sdr_be      (sdr_be),
        .sdr_we      (sdr_we),
        .sdr_req     (sdr_req),
        .sdr_ack     (sdr_ack),
        .sdr_q       (sdr_q),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    be;
        logic          we;
    } dreq_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Requester-side copies of each slice, owned by the bench.
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_data [N];
    logic [1:0]    r_be   [N];
    logic          r_we   [N];

    // Reference model: outstanding set, round-robin pointer, expected outputs, due cycles.
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_ack;
    logic [N-1:0]  m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_q;
    logic          m_sdr_req;
    logic [43:0]   m_bus;
    logic          m_engaged;
    int            m_last;
    int            m_g;
    int            cyc;
    int            issue_due;
    int            ack_drive;
    int            ack_due;
    int            lat_fixed;
    bit            q_use_fixed;
    logic [DW-1:0] q_fixed;
    int            dir_ioctl;
    dreq_t         dir_q[$];
    int            issued_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic int rr_pick(input logic [N-1:0] e);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (e[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic toggle_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [1:0] be, input logic we);
        r_addr[i] = a;
        r_data[i] = d;
        r_be[i]   = be;
        r_we[i]   = we;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req_be[i*2 +: 2]     = be;
        req_we[i]            = we;
        req_tog[i]           = ~req_tog[i];
        m_pend[i]            = 1'b1;
    endtask

    task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] be, input logic we);
        dreq_t r;
        r.idx = i; r.addr = a; r.data = d; r.be = be; r.we = we;
        dir_q.push_back(r);
    endtask

    task automatic model_reset();
        m_ack     = '0;
        m_pend    = req_tog;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_sdr_req = 1'b0;
        m_bus     = '0;
        m_engaged = 1'b0;
        m_last    = N - 1;
        issue_due = -1;
        ack_drive = -1;
        ack_due   = -1;
        sdr_ack   = 1'b0;
    endtask

    task automatic decide();
        logic [N-1:0] elig;
        if (!m_engaged) begin
            elig = ioctl_downl ? (m_pend & N'(1)) : m_pend;
            if (elig != '0) begin
                m_g       = rr_pick(elig);
                m_last    = m_g;
                issue_due = cyc + 2;
                m_engaged = 1'b1;
            end
        end
    endtask

    task automatic step(input bit rnd);
        dreq_t r;
        int    lat;
        @(negedge sys_clk);
        cyc++;
        m_rvalid = '0;
        if (cyc == issue_due) begin
            m_sdr_req = ~m_sdr_req;
            m_bus     = {r_we[m_g], r_be[m_g], r_data[m_g], r_addr[m_g]};
            issued_q.push_back(m_g);
            lat       = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 5));
            ack_drive = cyc + lat;
            issue_due = -1;
        end
        if (cyc == ack_due) begin
            m_ack[m_g]  = ~m_ack[m_g];
            m_pend[m_g] = 1'b0;
            if (!r_we[m_g]) begin
                m_rdata       = m_q;
                m_rvalid[m_g] = 1'b1;
            end
            m_engaged = 1'b0;
            ack_due   = -1;
        end
        check("ack_tog", ack_tog, m_ack);
        check("rvalid", rvalid, m_rvalid);
        check("rdata", rdata, m_rdata);
        check("busy", busy, m_engaged);
        check("sdr_req", sdr_req, m_sdr_req);
        check("sdr_bus", {sdr_we, sdr_be, sdr_data, sdr_addr}, m_bus);
        check("timeout_err", timeout_err, 1'b0);
        if (cyc == ack_drive) begin
            m_q       = q_use_fixed ? q_fixed : DW'($urandom);
            sdr_q     = m_q;
            sdr_ack   = m_sdr_req;
            ack_due   = cyc + 1;
            ack_drive = -1;
        end
        if (dir_ioctl >= 0) begin
            ioctl_downl = dir_ioctl[0];
            dir_ioctl   = -1;
        end
        while (dir_q.size() > 0) begin
            r = dir_q.pop_front();
            toggle_req(r.idx, r.addr, r.data, r.be, r.we);
        end
        if (rnd) begin
            for (int i = 0; i < N; i++)
                if (!m_pend[i] && $urandom_range(0, 3) == 0)
                    toggle_req(i, AW'($urandom), DW'($urandom), 2'($urandom), 1'($urandom));
            if ($urandom_range(0, 15) == 0)
                ioctl_downl = ~ioctl_downl;
        end
        decide();
    endtask

    task automatic run_until_idle(input int bound, input string tag);
        int k;
        for (k = 0; k < bound; k++) begin
            if (!m_engaged && m_pend == '0 && dir_q.size() == 0) break;
            step(1'b0);
        end
        check(tag, k < bound, 1'b1);
    endtask

    task automatic run_until_free(input int i, input int bound, input string tag);
        int k;
        for (k = 0; k < bound; k++) begin
            if (!m_pend[i] && dir_q.size() == 0) break;
            step(1'b0);
        end
        check(tag, k < bound, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n     = 1'b0;
        ioctl_downl = 1'b0;
        req_tog     = '0;
        req_addr    = '0;
        req_data    = '0;
        req_be      = '0;
        req_we      = '0;
        sdr_q       = '0;
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0; r_data[i] = '0; r_be[i] = '0; r_we[i] = 1'b0;
        end
        cyc         = 0;
        lat_fixed   = -1;
        q_use_fixed = 1'b0;
        q_fixed     = '0;
        dir_ioctl   = -1;
        m_g         = 0;
        m_q         = '0;
        model_reset();

        repeat (3) @(negedge sys_clk);
        check("rst_busy", busy, 1'b0);
        check("rst_sdr_req", sdr_req, 1'b0);
        check("rst_ack_tog", ack_tog, '0);
        check("rst_rvalid", rvalid, '0);
        check("rst_rdata", rdata, '0);
        check("rst_sdr_bus", {sdr_we, sdr_be, sdr_data, sdr_addr}, '0);
        check("rst_timeout_err", timeout_err, 1'b0);
        reset_n = 1'b1;

        // Single read from the loader, controller answers 5 cycles after the request toggle.
        lat_fixed   = 5;
        q_use_fixed = 1'b1;
        q_fixed     = 16'h1234;
        push(0, 25'h000100, 16'h0000, 2'b11, 1'b0);
        run_until_idle(100, "rd0_done");
        check("rd0_rdata", rdata, 16'h1234);
        check("rd0_addr", sdr_addr, 25'h000100);
        check("rd0_we", sdr_we, 1'b0);
        check("rd0_ack", ack_tog[0], 1'b1);

        // Simultaneous requests 1,2,3 after grant 0: served in order 1,2,3.
        q_use_fixed = 1'b0;
        lat_fixed   = -1;
        issued_q.delete();
        for (int i = 1; i < N; i++)
            push(i, AW'($urandom), DW'($urandom), 2'b11, 1'b0);
        run_until_idle(200, "rr_done");
        check("rr_count", issued_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("rr_order", issued_q[i], i + 1);
        check("rr_ack_tog", ack_tog, 4'b1111);

        // Download active: only the loader is served while requester 2 waits.
        issued_q.delete();
        dir_ioctl = 1;
        push(2, AW'($urandom), DW'($urandom), 2'b01, 1'b0);
        for (int rep = 0; rep < 3; rep++) begin
            push(0, AW'($urandom), DW'($urandom), 2'b11, 1'($urandom));
            run_until_free(0, 100, "dl_loader_done");
        end
        check("dl_count", issued_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("dl_only0", issued_q[i], 0);
        dir_ioctl = 0;
        run_until_free(2, 100, "dl_req2_done");
        check("dl_then2", issued_q[3], 2);
        check("dl_ack_tog", ack_tog, 4'b1010);

        // Write from requester 3 at the top address with a partial byte enable.
        push(3, 25'h1FFFFFF, 16'hA55A, 2'b10, 1'b1);
        run_until_idle(100, "wr3_done");
        check("wr3_we", sdr_we, 1'b1);
        check("wr3_be", sdr_be, 2'b10);
        check("wr3_addr", sdr_addr, 25'h1FFFFFF);
        check("wr3_data", sdr_data, 16'hA55A);
        check("wr3_ack_tog", ack_tog, 4'b0010);

        // Randomized traffic with random download toggling and controller latency.
        for (int k = 0; k < 3000; k++)
            step(1'b1);
        dir_ioctl = 0;
        run_until_idle(500, "rand_drain");

        // Reset asserted in the middle of a long WAIT.
        lat_fixed = 20;
        push(1, AW'($urandom), DW'($urandom), 2'b11, 1'b0);
        repeat (5) step(1'b0);
        check("rstw_in_wait", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rstw_async_ctl", {busy, sdr_req, ack_tog, rvalid}, '0);
        check("rstw_async_data", {rdata, sdr_we, sdr_be, sdr_data, sdr_addr}, '0);
        if (!req_tog[0])
            toggle_req(0, AW'($urandom), DW'($urandom), 2'b11, 1'b0);
        model_reset();
        lat_fixed = -1;
        @(negedge sys_clk);
        cyc++;
        reset_n = 1'b1;
        issued_q.delete();
        decide();
        run_until_idle(300, "rstw_drain");
        check("rstw_first_grant", issued_q[0], 0);

`ifdef SDR_ARB_TIMEOUT_EN
        // Controller never answers: watchdog forces completion after ~64K WAIT cycles.
        @(negedge sys_clk);
        toggle_req(0, 25'h0000042, 16'h0000, 2'b11, 1'b0);
        for (n = 0; n < 70000; n++) begin
            @(negedge sys_clk);
            if (ack_tog[0] != m_ack[0]) break;
        end
        check("to_window", (n > 65000) && (n < 66000), 1'b1);
        check("to_rdata", rdata, 16'hDEAD);
        check("to_rvalid", rvalid, 4'b0001);
        check("to_err", timeout_err, 1'b1);
        check("to_req_realigned", sdr_req, sdr_ack);
        repeat (10) @(negedge sys_clk);
        check("to_err_sticky", timeout_err, 1'b1);
        check("to_idle", busy, 1'b0);
`else
        n = 0;
        repeat (50) @(negedge sys_clk);
        check("no_timeout_err", timeout_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
